// File: rtl/user_move_ctrl_pkg.sv
// Shared game constants and the movement controller state type.
package user_move_ctrl_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int SPRITE_W = 28;
  localparam int SPRITE_H = 20;

  typedef enum logic [2:0] {
    ST_INIT_DRAW  = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_IDLE       = 3'd2,
    ST_ERASE      = 3'd3,
    ST_WAIT_ERASE = 3'd4,
    ST_MOVE       = 3'd5,
    ST_DRAW       = 3'd6,
    ST_WAIT_DRAW  = 3'd7
  } move_state_e;

endpackage

// File: rtl/user_x_clamp.sv
// Combinational target x for one frame step, clamped to [0, X_MAX] without wrap.
module user_x_clamp #(
  parameter int X_MAX = 292,
  parameter int STEP  = 2
) (
  input  logic [8:0] x_cur,
  input  logic       move_left,
  input  logic       move_right,
  output logic [8:0] x_target,
  output logic       move_ok
);

  logic [9:0] x_ext_s;
  logic [9:0] step_s;
  logic [9:0] max_s;
  logic [9:0] sum_s;

  // Widen to 10 bits so the subtract/add limits are compared before truncation.
  always_comb begin
    x_ext_s  = {1'b0, x_cur};
    step_s   = 10'(STEP);
    max_s    = 10'(X_MAX);
    sum_s    = x_ext_s + step_s;
    x_target = x_cur;
    if (move_left && !move_right) begin
      if (x_ext_s < step_s) begin
        x_target = 9'd0;
      end else begin
        x_target = 9'(x_ext_s - step_s);
      end
    end else if (move_right && !move_left) begin
      if (sum_s > max_s) begin
        x_target = 9'(max_s);
      end else begin
        x_target = sum_s[8:0];
      end
    end else begin
      x_target = x_cur;
    end
    move_ok = (x_target != x_cur);
  end

endmodule

// File: rtl/user_move_ctrl.sv
// Player sprite controller: per-frame left/right step as erase-move-redraw plot sequence.
module user_move_ctrl
  import user_move_ctrl_pkg::*;
#(
  parameter int X_INIT = 146,
  parameter int Y_ROW  = 200,
  parameter int X_MAX  = SCREEN_W - SPRITE_W,
  parameter int STEP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       draw_done,
  output logic       draw_start,
  output logic       erase,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       busy
);

  move_state_e state_r;
  move_state_e state_s;
  logic [8:0]  x_pos_r;
  logic [8:0]  next_x_r;
  logic [8:0]  target_s;
  logic        move_ok_s;

  user_x_clamp #(
    .X_MAX (X_MAX),
    .STEP  (STEP)
  ) u_clamp (
    .x_cur      (x_pos_r),
    .move_left  (move_left),
    .move_right (move_right),
    .x_target   (target_s),
    .move_ok    (move_ok_s)
  );

  // Next-state logic; ticks outside IDLE are simply not looked at.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT_DRAW:  state_s = ST_WAIT_INIT;
      ST_WAIT_INIT:  if (draw_done) state_s = ST_IDLE; else state_s = ST_WAIT_INIT;
      ST_IDLE:       if (frame_tick && move_ok_s) state_s = ST_ERASE; else state_s = ST_IDLE;
      ST_ERASE:      state_s = ST_WAIT_ERASE;
      ST_WAIT_ERASE: if (draw_done) state_s = ST_MOVE; else state_s = ST_WAIT_ERASE;
      ST_MOVE:       state_s = ST_DRAW;
      ST_DRAW:       state_s = ST_WAIT_DRAW;
      ST_WAIT_DRAW:  if (draw_done) state_s = ST_IDLE; else state_s = ST_WAIT_DRAW;
      default:       state_s = ST_INIT_DRAW;
    endcase
  end

  // State and position registers; x_pos only ever changes in MOVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_INIT_DRAW;
      x_pos_r  <= 9'(X_INIT);
      next_x_r <= 9'(X_INIT);
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && frame_tick && move_ok_s) begin
        next_x_r <= target_s;
      end
      if (state_r == ST_MOVE) begin
        x_pos_r <= next_x_r;
      end
    end
  end

  // Plot strobes decode the state register; masked while reset is held.
  always_comb begin
    draw_start = 1'b0;
    erase      = 1'b0;
    if (!reset) begin
      draw_start = (state_r == ST_INIT_DRAW) || (state_r == ST_ERASE) || (state_r == ST_DRAW);
      erase      = (state_r == ST_ERASE) || (state_r == ST_WAIT_ERASE);
    end else begin
      draw_start = 1'b0;
      erase      = 1'b0;
    end
  end

  assign busy  = reset || (state_r != ST_IDLE);
  assign x_pos = x_pos_r;
  assign y_pos = 8'(Y_ROW);

endmodule

// File: tb/tb_user_move_ctrl.sv
// Randomized and directed bench for user_move_ctrl against a transaction-level plot model.
module tb_user_move_ctrl;

  localparam int X_INIT_TB = 146;
  localparam int Y_ROW_TB  = 200;
  localparam int X_MAX_TB  = 292;
  localparam int STEP_TB   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, move_left = 1'b0, move_right = 1'b0, draw_done = 1'b0;
  logic       draw_start, erase, busy;
  logic [8:0] x_pos;
  logic [7:0] y_pos;

  logic       ft_e = 1'b0, ml_e = 1'b0, mr_e = 1'b0, dd_e = 1'b0;
  logic       ds_b, er_b, busy_b, ds_c, er_c, busy_c;
  logic [8:0] x_b, x_c;
  logic [7:0] y_b, y_c;

  user_move_ctrl u_dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_left(move_left),
    .move_right(move_right), .draw_done(draw_done), .draw_start(draw_start),
    .erase(erase), .x_pos(x_pos), .y_pos(y_pos), .busy(busy)
  );

  user_move_ctrl #(.X_INIT(291)) u_dut_b (
    .clk(clk), .reset(reset), .frame_tick(ft_e), .move_left(ml_e),
    .move_right(mr_e), .draw_done(dd_e), .draw_start(ds_b),
    .erase(er_b), .x_pos(x_b), .y_pos(y_b), .busy(busy_b)
  );

  user_move_ctrl #(.X_INIT(1)) u_dut_c (
    .clk(clk), .reset(reset), .frame_tick(ft_e), .move_left(ml_e),
    .move_right(mr_e), .draw_done(dd_e), .draw_start(ds_c),
    .erase(er_c), .x_pos(x_c), .y_pos(y_c), .busy(busy_c)
  );

  int checks = 0;
  int errors = 0;

  // Model of the plot traffic for u_dut: expected draw_start events and plot in flight
  int   now = 0;
  int   model_x = X_INIT_TB;
  int   new_x = X_INIT_TB;
  logic ds_pend = 1'b0, ds_er = 1'b0;
  int   ds_cyc = 0, ds_x = X_INIT_TB;
  logic infl = 1'b0, infl_er = 1'b0;
  int   done_at = 0;
  logic xupd_pend = 1'b0;
  int   move_cyc = -1;
  int   rst_held = 0;
  logic first_init = 1'b1;
  int   xb_m = 291, xc_m = 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int target_of(input int x, input logic l, input logic r);
    if (l && !r) return (x - STEP_TB < 0) ? 0 : x - STEP_TB;
    else if (r && !l) return (x + STEP_TB > X_MAX_TB) ? X_MAX_TB : x + STEP_TB;
    else return x;
  endfunction

  // One clock of u_dut: drive at posedge+1, check at negedge, advance the model.
  task automatic a_cycle(input logic ft, input logic ml, input logic mr, input logic rst);
    logic idle_s, exp_ds, dd;
    int   t;
    idle_s = !ds_pend && !infl;
    dd = 1'b0;
    if (!rst) begin
      if (infl && now == done_at) dd = 1'b1;
      else if (idle_s || now == move_cyc) dd = ($urandom_range(0, 3) == 0);
    end
    reset = rst; frame_tick = ft; move_left = ml; move_right = mr; draw_done = dd;
    @(negedge clk);
    if (rst) begin
      chk1("rst_draw_start", draw_start, 1'b0);
      if (rst_held > 0) begin
        chk1("rst_erase", erase, 1'b0);
        chk1("rst_busy", busy, 1'b1);
        chk9("rst_x_pos", x_pos, 9'(X_INIT_TB));
      end
      rst_held++;
      ds_pend = 1'b1; ds_cyc = now + 1; ds_er = 1'b0; ds_x = X_INIT_TB;
      infl = 1'b0; xupd_pend = 1'b0; model_x = X_INIT_TB; move_cyc = -1;
    end else begin
      rst_held = 0;
      exp_ds = ds_pend && (ds_cyc == now);
      chk1("draw_start", draw_start, exp_ds);
      chk1("erase", erase, exp_ds ? ds_er : (infl && infl_er));
      chk9("x_pos", x_pos, 9'(model_x));
      chk1("busy", busy, !idle_s);
      chk9("y_pos", {1'b0, y_pos}, 9'(Y_ROW_TB));
      if (exp_ds) begin
        chk9("plot_x", x_pos, 9'(ds_x));
        ds_pend = 1'b0; infl = 1'b1; infl_er = ds_er;
        done_at = now + (first_init ? 560 : int'($urandom_range(1, 5)));
        first_init = 1'b0;
      end else if (dd && infl) begin
        infl = 1'b0;
        if (infl_er) begin
          ds_pend = 1'b1; ds_cyc = now + 2; ds_er = 1'b0; ds_x = new_x;
          xupd_pend = 1'b1; move_cyc = now + 1;
        end
      end
      if (ft && idle_s) begin
        t = target_of(model_x, ml, mr);
        if (t != model_x) begin
          ds_pend = 1'b1; ds_cyc = now + 1; ds_er = 1'b1; ds_x = model_x; new_x = t;
        end
      end
      if (xupd_pend && now == move_cyc) begin
        model_x = new_x; xupd_pend = 1'b0;
      end
    end
    @(posedge clk); #1;
    now++;
  endtask

  task automatic bc_chk(input string n, input logic ds, input logic er, input logic bz,
                        input logic [8:0] x, input int o, input int t, input int k);
    logic mv;
    mv = (t != o);
    chk1({n, "_draw_start"}, ds, mv && (k == 1 || k == 5));
    chk1({n, "_erase"}, er, mv && k >= 1 && k <= 3);
    chk1({n, "_busy"}, bz, mv && k >= 1 && k <= 7);
    chk9({n, "_x_pos"}, x, 9'((mv && k >= 5) ? t : o));
  endtask

  // Lock-step step for the two limit instances with fixed plotter timing.
  task automatic bc_step(input logic l, input logic r);
    int tb_t, tc_t;
    tb_t = target_of(xb_m, l, r);
    tc_t = target_of(xc_m, l, r);
    ml_e = l; mr_e = r;
    for (int k = 0; k <= 8; k++) begin
      ft_e = (k == 0);
      dd_e = (k == 3) || (k == 7);
      @(negedge clk);
      bc_chk("b", ds_b, er_b, busy_b, x_b, xb_m, tb_t, k);
      bc_chk("c", ds_c, er_c, busy_c, x_c, xc_m, tc_t, k);
      @(posedge clk); #1;
    end
    ft_e = 1'b0; dd_e = 1'b0;
    xb_m = tb_t; xc_m = tc_t;
  endtask

  initial begin
    logic reached;
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 700 && (ds_pend || infl); i++) a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("init_busy", busy, 1'b0);
    chk9("init_x", x_pos, 9'd146);

    a_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && (ds_pend || infl); i++) a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk9("right_x", x_pos, 9'd148);
    chk1("right_busy", busy, 1'b0);

    for (int i = 0; i < 1500; i++)
      a_cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);

    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (infl && !infl_er) reached = 1'b1;
      else a_cycle(1'b1, model_x >= 150, model_x < 150, 1'b0);
    end
    if (!reached) begin
      checks++; errors++;
      $error("FAIL wait_draw_bound observed %0d expected %0d", 0, 1);
    end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && (ds_pend || infl); i++) a_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("post_reset_busy", busy, 1'b0);
    chk9("post_reset_x", x_pos, 9'd146);

    dd_e = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    dd_e = 1'b0;
    @(negedge clk);
    chk1("b_init_busy", busy_b, 1'b0);
    chk1("c_init_busy", busy_c, 1'b0);
    chk9("b_init_x", x_b, 9'd291);
    chk9("c_init_x", x_c, 9'd1);
    chk9("c_y_pos", {1'b0, y_c}, 9'(Y_ROW_TB));
    @(posedge clk); #1;
    bc_step(1'b0, 1'b1);
    bc_step(1'b0, 1'b1);
    bc_step(1'b1, 1'b0);
    bc_step(1'b1, 1'b0);
    bc_step(1'b1, 1'b0);
    bc_step(1'b1, 1'b0);
    bc_step(1'b1, 1'b1);
    bc_step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
